computation_unit: RTL and testbench



---
 rtl/computation_unit.sv | 137 +++++++++++++
 tb/tb_computation_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/computation_unit.sv
// Datapath computation stage: operand select, B shifter, extended ALU with an
// iterative shift-and-add multiplier, result register C and Z/N/V status.
module computation_unit #(
  parameter int WIDTH = 16,
  parameter int IMMW  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             asel,
  input  logic             bsel,
  input  logic             loadc,
  input  logic             loads,
  input  logic [1:0]       shift,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [2:0]       status,
  output logic [WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             loadc;
    logic             loads;
  } mul_ctx_t;

  state_t           state, state_nx;
  mul_ctx_t         ctx;
  logic [WIDTH-1:0] ain, bshift, bin, result, acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             v_flag, is_mul, last_step;
  logic             unused_dp;

  // Only the low IMMW bits of datapath_in feed the immediate.
  assign unused_dp = ^datapath_in;

  assign ain    = asel ? '0 : A;
  assign bin    = bsel ? WIDTH'(datapath_in[IMMW-1:0]) : bshift;
  assign is_mul = (ALUop == OP_MUL);
  assign busy   = (state == MUL);

  always_comb begin
    bshift = B;
    unique case (shift)
      2'b00: bshift = B;
      2'b01: bshift = {B[WIDTH-2:0], 1'b0};
      2'b10: bshift = {1'b0, B[WIDTH-1:1]};
      2'b11: bshift = {B[WIDTH-1], B[WIDTH-1:1]};
    endcase
  end

  // Single-cycle ALU; MUL goes through the iterative path instead.
  always_comb begin
    result = '0;
    v_flag = 1'b0;
    unique case (ALUop)
      3'b000: begin
        result = ain + bin;
        v_flag = (ain[WIDTH-1] == bin[WIDTH-1]) && (result[WIDTH-1] != ain[WIDTH-1]);
      end
      3'b001: begin
        result = ain - bin;
        v_flag = (ain[WIDTH-1] != bin[WIDTH-1]) && (result[WIDTH-1] != ain[WIDTH-1]);
      end
      3'b010: result = ain & bin;
      3'b011: result = ~bin;
      3'b100: result = '0;
      3'b101: result = ain | bin;
      3'b110: result = ain ^ bin;
      3'b111: result = '0;
    endcase
  end

  assign acc_step  = ctx.mplier[0] ? acc + ctx.mcand : acc;
  assign last_step = (state == MUL) && (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && is_mul) state_nx = MUL;
      MUL:  if (last_step)       state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      C      <= '0;
      status <= 3'b000;
      done   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      ctx    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && is_mul) begin
            ctx <= '{mcand: ain, mplier: bin, loadc: loadc, loads: loads};
            acc <= '0;
            cnt <= '0;
          end else if (start) begin
            if (loadc) C      <= result;
            if (loads) status <= {v_flag, result[WIDTH-1], ~|result};
            done <= 1'b1;
          end
        end
        MUL: begin
          acc        <= acc_step;
          ctx.mcand  <= {ctx.mcand[WIDTH-2:0], 1'b0};
          ctx.mplier <= {1'b0, ctx.mplier[WIDTH-1:1]};
          cnt        <= cnt + CW'(1);
          if (last_step) begin
            if (ctx.loadc) C      <= acc_step;
            if (ctx.loads) status <= {1'b0, acc_step[WIDTH-1], ~|acc_step};
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_computation_unit.sv
// Directed plus randomized checks of computation_unit against an arithmetic reference model.
module tb_computation_unit;
  localparam int W  = 16;
  localparam int IW = 5;

  logic         clk = 1'b0;
  logic         resetn, start, asel, bsel, loadc, loads;
  logic [1:0]   shift;
  logic [2:0]   ALUop;
  logic [W-1:0] datapath_in, A, B;
  logic         busy, done;
  logic [2:0]   status;
  logic [W-1:0] C;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_c;
  logic [2:0]   exp_s;

  always #5 clk = ~clk;

  computation_unit #(.WIDTH(W), .IMMW(IW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
    .datapath_in(datapath_in), .A(A), .B(B),
    .busy(busy), .done(done), .status(status), .C(C)
  );

  // Returns {status, result} computed with plain integer arithmetic.
  function automatic logic [W+2:0] ref_op(input logic as, input logic bs, input logic [1:0] sh,
                                          input logic [2:0] op, input logic [W-1:0] dp,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    longint m, half, ua, ub, sa, sb, sr, r;
    logic v, z, n;
    logic [W+2:0] out;
    m    = longint'(1) << W;
    half = m / 2;
    ua   = as ? 0 : longint'(a);
    case (sh)
      2'd0:    ub = longint'(b);
      2'd1:    ub = (longint'(b) * 2) % m;
      2'd2:    ub = longint'(b) / 2;
      default: ub = longint'(b) / 2 + ((longint'(b) >= half) ? half : 0);
    endcase
    if (bs) ub = longint'(dp) % (longint'(1) << IW);
    sa = (ua >= half) ? ua - m : ua;
    sb = (ub >= half) ? ub - m : ub;
    sr = 0;
    case (op)
      3'd0: begin r = (ua + ub) % m;     sr = sa + sb; end
      3'd1: begin r = (ua - ub + m) % m; sr = sa - sb; end
      3'd2: r = ua & ub;
      3'd3: r = (m - 1) - ub;
      3'd4: r = (ua * ub) % m;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: r = 0;
    endcase
    v = (op <= 3'd1) && (sr >= half || sr < -half);
    z = (r == 0);
    n = (r >= half);
    out = {v, n, z, r[W-1:0]};
    return out;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic scramble();
    {asel, bsel, loadc, loads} = 4'($urandom);
    shift       = 2'($urandom);
    ALUop       = 3'($urandom);
    A           = W'($urandom);
    B           = W'($urandom);
    datapath_in = W'($urandom);
    start       = 1'($urandom);
  endtask

  // Issues one op at a negedge and checks completion; leaves the bench at a negedge.
  task automatic run_op(input logic as, input logic bs, input logic lc, input logic ls,
                        input logic [1:0] sh, input logic [2:0] op,
                        input logic [W-1:0] dp, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+2:0] r;
    int n;
    asel = as; bsel = bs; loadc = lc; loads = ls; shift = sh; ALUop = op;
    datapath_in = dp; A = a; B = b; start = 1'b1;
    r = ref_op(as, bs, sh, op, dp, a, b);
    @(posedge clk); @(negedge clk);
    if (op == 3'd4) begin
      n = 0;
      while (done !== 1'b1 && n < 3 * W) begin
        chk("mul_busy", 32'(busy), 32'd1);
        scramble();
        @(posedge clk); @(negedge clk);
        n++;
      end
      chk("mul_latency", 32'(n), 32'(W));
    end
    start = 1'b0;
    if (lc) exp_c = r[W-1:0];
    if (ls) exp_s = r[W+2:W];
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("C", 32'(C), 32'(exp_c));
    chk("status", 32'(status), 32'(exp_s));
  endtask

  initial begin
    int pulses;
    resetn = 1'b1; start = 1'b0; asel = 1'b0; bsel = 1'b0; loadc = 1'b0; loads = 1'b0;
    shift = 2'd0; ALUop = 3'd0; datapath_in = '0; A = '0; B = '0;
    exp_c = '0; exp_s = '0;

    // Random activity, then a single reset edge
    @(negedge clk);
    repeat (12) begin scramble(); @(negedge clk); end
    start = 1'b0; resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    chk("rst_C", 32'(C), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    run_op(0, 0, 1, 1, 2'b00, 3'b000, 16'h0000, 16'h7FFF, 16'h0001);
    chk("add_ovf_C", 32'(C), 32'h8000);
    chk("add_ovf_status", 32'(status), 32'b110);
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    run_op(0, 0, 1, 1, 2'b00, 3'b001, 16'h0000, 16'h0005, 16'h0005);
    chk("sub_zero_C", 32'(C), 32'h0000);
    chk("sub_zero_status", 32'(status), 32'b001);
    run_op(1, 0, 1, 1, 2'b11, 3'b000, 16'h0000, 16'h1234, 16'h8004);
    chk("asr_C", 32'(C), 32'hC002);
    chk("asr_status", 32'(status), 32'b010);
    run_op(0, 1, 1, 1, 2'b00, 3'b000, 16'hFFFF, 16'h0003, 16'h0000);
    chk("imm_C", 32'(C), 32'h0022);
    chk("imm_status", 32'(status), 32'b000);

    run_op(0, 0, 1, 1, 2'b00, 3'b100, 16'h0000, 16'h0012, 16'h0034);
    chk("mul_C", 32'(C), 32'h03A8);
    chk("mul_status", 32'(status), 32'b000);
    @(posedge clk); @(negedge clk);
    chk("mul_single_done", 32'(done), 32'd0);

    // Abort a multiply on its 8th busy cycle
    asel = 0; bsel = 0; loadc = 1; loads = 1; shift = 0; ALUop = 3'b100;
    A = 16'h0012; B = 16'h0034; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    chk("abort_busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    exp_c = '0; exp_s = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_C", 32'(C), 32'h0);
    pulses = 0;
    repeat (2 * W) begin @(posedge clk); @(negedge clk); if (done === 1'b1) pulses++; end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // Hold behaviour
    run_op(0, 0, 1, 1, 2'b00, 3'b000, 16'h0000, 16'h0005, 16'h0003);
    run_op(0, 0, 0, 1, 2'b00, 3'b111, 16'h0000, 16'hAAAA, 16'h5555);
    chk("hold_C", 32'(C), 32'h0008);
    chk("hold_status", 32'(status), 32'b001);
    loadc = 1'b1; loads = 1'b1; ALUop = 3'b000; A = 16'h1111; B = 16'h2222;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("nostart_done", 32'(done), 32'd0);
      chk("nostart_C", 32'(C), 32'(exp_c));
      chk("nostart_status", 32'(status), 32'(exp_s));
    end

    // Randomized back-to-back ops, multiplies included
    repeat (40) begin
      logic [3:0] ctl;
      ctl = 4'($urandom);
      run_op(ctl[0], ctl[1], ctl[2], ctl[3], 2'($urandom), 3'($urandom),
             W'($urandom), W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
